imm_extend_pipe: RTL

//  Parametrised, pipelined immediate/field extender for the ID stage: takes a raw instruction field

---
 rtl/imm_extend_pipe_pkg.sv | 19 +
 rtl/imm_extend_pipe_if.sv | 28 ++
 rtl/imm_extend_core.sv | 40 ++++
 rtl/imm_extend_pipe.sv | 86 ++++++++
 4 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared extend-mode encoding for the ID-stage immediate extender.
package imm_extend_pipe_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t EXT_ZEXT = 3'd0;
    localparam mode_t EXT_SEXT = 3'd1;
    localparam mode_t EXT_ZSH  = 3'd2;
    localparam mode_t EXT_LUI  = 3'd3;
    localparam mode_t EXT_BR   = 3'd4;

    // Every encoding above EXT_BR is reserved and yields data 0 with err set.
    function automatic logic mode_reserved(input mode_t mode);
        return mode > EXT_BR;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode, the extender and the ID/EX register.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    import imm_extend_pipe_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_field;
    mode_t            in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output flush, in_valid, in_field, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  flush, in_valid, in_field, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/imm_extend_core.sv
// Combinational field+mode -> extended operand; zero latency, no state, no backpressure.
module imm_extend_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [IN_W-1:0]  field,
    input  mode_t            mode,
    output logic [OUT_W-1:0] data,
    output logic             err
);

    if (OUT_W < 2 * IN_W) begin : g_bad_out_w
        $error("imm_extend_core: OUT_W must be >= 2*IN_W");
    end
    if (SHAMT_W > IN_W || SHAMT_W < 1) begin : g_bad_shamt_w
        $error("imm_extend_core: SHAMT_W must be in 1..IN_W");
    end

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){field[IN_W-1]}}, field};

    always_comb begin
        data = '0;
        err  = mode_reserved(mode);
        case (mode)
            EXT_ZEXT: data = {{(OUT_W-IN_W){1'b0}}, field};
            EXT_SEXT: data = sext;
            EXT_ZSH:  data = {{(OUT_W-SHAMT_W){1'b0}}, field[SHAMT_W-1:0]};
            EXT_LUI:  data = {field, {(OUT_W-IN_W){1'b0}}};
            // Branch offsets are word-scaled; bits shifted past OUT_W are dropped.
            EXT_BR:   data = {sext[OUT_W-3:0], 2'b00};
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: 1-cycle latency, 2-entry skid (main + skid) absorbs stalls;
// in_ready is registered (!skid_valid) so out_ready never reaches in_ready combinationally.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          Clk,
    input  logic          Reset_n,
    imm_extend_pipe_if.slave bus
);

    if (OUT_W < 2 * IN_W) begin : g_bad_out_w
        $error("imm_extend_pipe: OUT_W must be >= 2*IN_W");
    end
    if (SHAMT_W > IN_W || SHAMT_W < 1) begin : g_bad_shamt_w
        $error("imm_extend_pipe: SHAMT_W must be in 1..IN_W");
    end

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    logic             main_valid;
    logic [OUT_W-1:0] main_data;
    logic             main_err;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;

    logic             accept;
    logic             drain;

    imm_extend_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .field (bus.in_field),
        .mode  (bus.in_mode),
        .data  (ext_data),
        .err   (ext_err)
    );

    assign accept = bus.in_valid && !skid_valid;
    assign drain  = !main_valid || bus.out_ready;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (bus.flush) begin
            // Squash drops held entries and any input offered this cycle.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= ext_data;
                main_err   <= ext_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_err   <= ext_err;
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_err   = main_err;

endmodule
